// File: rtl/commit_retire_ctrl.sv
// commit_retire_ctrl: commit ring completion tracking, in-order group retire and free-entry accounting
module commit_retire_ctrl #(
    parameter int NCOMMIT  = 32,
    parameter int LNCOMMIT = 5,
    parameter int NALU     = 2,
    parameter int NALLOC   = 4,
    parameter int NRETIRE  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     alloc_valid,
    input  logic [2:0]               alloc_count,
    output logic                     alloc_ready,
    input  logic [NALU-1:0]          complete_valid,
    input  logic [NALU*LNCOMMIT-1:0] complete_commit,
    input  logic [NALU-1:0]          complete_exc,
    output logic                     retire_valid,
    output logic [LNCOMMIT-1:0]      retire_base,
    output logic [2:0]               retire_count,
    output logic                     retire_exc,
    input  logic                     retire_ack,
    output logic [LNCOMMIT-1:0]      head,
    output logic [LNCOMMIT-1:0]      tail,
    output logic [LNCOMMIT:0]        num_free
);
    logic [NCOMMIT-1:0]  valid, done, exc;
    logic [NCOMMIT-1:0]  valid_n, done_n, exc_n;
    logic [LNCOMMIT:0]   occ;
    logic [LNCOMMIT-1:0] gi, ai, ci, ri;
    logic                stop, alloc_fire, ret_fire;

    assign num_free    = (LNCOMMIT+1)'(NCOMMIT) - occ;
    assign alloc_ready = num_free >= (LNCOMMIT+1)'(NALLOC);
    assign retire_base = head;
    assign retire_valid = retire_count != 3'd0;
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign ret_fire    = retire_ack && retire_valid;

    // Retire group: a lone excepting head entry, else the run of clean done entries from head
    always_comb begin
        retire_count = 3'd0;
        retire_exc = 1'b0;
        stop = 1'b0;
        gi = head;
        if (valid[head] && done[head] && exc[head]) begin
            retire_count = 3'd1;
            retire_exc = 1'b1;
        end else begin
            for (int i = 0; i < NRETIRE; i++) begin
                gi = head + LNCOMMIT'(i);
                if (!stop && valid[gi] && done[gi] && !exc[gi]) retire_count = retire_count + 3'd1;
                else stop = 1'b1;
            end
        end
    end

    // Next per-entry state: allocate at tail, record completions, clear the retired group
    always_comb begin
        valid_n = valid;
        done_n = done;
        exc_n = exc;
        ai = tail;
        ci = '0;
        ri = head;
        for (int i = 0; i < NALLOC; i++) begin
            ai = tail + LNCOMMIT'(i);
            if (alloc_fire && 3'(i) < alloc_count) begin
                valid_n[ai] = 1'b1;
                done_n[ai] = 1'b0;
                exc_n[ai] = 1'b0;
            end
        end
        for (int k = 0; k < NALU; k++) begin
            ci = complete_commit[k*LNCOMMIT +: LNCOMMIT];
            if (complete_valid[k] && valid[ci] && !done[ci]) begin
                done_n[ci] = 1'b1;
                exc_n[ci] = exc_n[ci] | complete_exc[k];
            end
        end
        for (int i = 0; i < NRETIRE; i++) begin
            ri = head + LNCOMMIT'(i);
            if (ret_fire && 3'(i) < retire_count) begin
                valid_n[ri] = 1'b0;
                done_n[ri] = 1'b0;
                exc_n[ri] = 1'b0;
            end
        end
    end

    // Ring state update; reset and flush both empty the ring and drop any pending group
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            valid <= '0;
            done <= '0;
            exc <= '0;
            head <= '0;
            tail <= '0;
            occ <= '0;
        end else begin
            valid <= valid_n;
            done <= done_n;
            exc <= exc_n;
            head <= head + (ret_fire ? LNCOMMIT'(retire_count) : '0);
            tail <= tail + (alloc_fire ? LNCOMMIT'(alloc_count) : '0);
            occ <= occ + (alloc_fire ? (LNCOMMIT+1)'(alloc_count) : '0)
                       - (ret_fire ? (LNCOMMIT+1)'(retire_count) : '0);
        end
    end

    // Flag protocol misuse: alloc without room, completion of a free or already-done entry
    always_ff @(posedge clk) begin
        if (!reset && !flush) begin
            assert (!alloc_valid || alloc_ready) else $warning("alloc dropped: ring lacks room");
            for (int k = 0; k < NALU; k++)
                assert (!complete_valid[k] || (valid[complete_commit[k*LNCOMMIT +: LNCOMMIT]]
                        && !done[complete_commit[k*LNCOMMIT +: LNCOMMIT]]))
                    else $warning("completion ignored on port %0d", k);
        end
    end
endmodule

// File: tb/tb_commit_retire_ctrl.sv
// tb_commit_retire_ctrl: directed scenarios for the commit ring retire controller
module tb_commit_retire_ctrl;
    logic       clk = 1'b0, reset = 1'b1, flush = 1'b0;
    logic       alloc_valid = 1'b0, alloc_ready;
    logic [2:0] alloc_count = 3'd0;
    logic [1:0] complete_valid = 2'b0, complete_exc = 2'b0;
    logic [9:0] complete_commit = 10'd0;
    logic       retire_valid, retire_exc, retire_ack = 1'b0;
    logic [4:0] retire_base, head, tail;
    logic [2:0] retire_count;
    logic [5:0] num_free;
    int errors = 0, checks = 0;

    commit_retire_ctrl dut (
        .clk(clk), .reset(reset), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_count(alloc_count), .alloc_ready(alloc_ready),
        .complete_valid(complete_valid), .complete_commit(complete_commit), .complete_exc(complete_exc),
        .retire_valid(retire_valid), .retire_base(retire_base), .retire_count(retire_count),
        .retire_exc(retire_exc), .retire_ack(retire_ack),
        .head(head), .tail(tail), .num_free(num_free)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    task automatic do_alloc(input int n);
        alloc_valid = 1'b1;
        alloc_count = 3'(n);
        cyc();
        alloc_valid = 1'b0;
    endtask

    task automatic do_complete(input bit v0, input int i0, input bit e0,
                               input bit v1, input int i1, input bit e1);
        complete_valid = {v1, v0};
        complete_commit = {5'(i1), 5'(i0)};
        complete_exc = {e1, e0};
        cyc();
        complete_valid = 2'b0;
        complete_exc = 2'b0;
    endtask

    task automatic do_ack();
        retire_ack = 1'b1;
        cyc();
        retire_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        checks++; if (retire_valid !== 1'b0) begin errors++; $display("FAIL reset_rv got %0d want 0", retire_valid); end
        checks++; if (retire_count !== 3'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", retire_count); end
        checks++; if (retire_exc !== 1'b0) begin errors++; $display("FAIL reset_exc got %0d want 0", retire_exc); end
        checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0d want 1", alloc_ready); end
        checks++; if (num_free !== 6'd32) begin errors++; $display("FAIL reset_free got %0d want 32", num_free); end
        checks++; if ({head, tail} !== 10'd0) begin errors++; $display("FAIL reset_ptrs got %0d/%0d want 0/0", head, tail); end
    endtask

    task automatic test_basic_retire();
        do_reset();
        do_alloc(4);
        checks++; if (num_free !== 6'd28) begin errors++; $display("FAIL t1_free_alloc got %0d want 28", num_free); end
        do_complete(1, 0, 0, 1, 1, 0);
        checks++; if (retire_count !== 3'd2) begin errors++; $display("FAIL t1_latency_cnt got %0d want 2", retire_count); end
        do_complete(1, 2, 0, 1, 3, 0);
        checks++; if ({retire_valid, retire_base, retire_count} !== {1'b1, 5'd0, 3'd4}) begin errors++;
            $display("FAIL t1_group got v=%0d b=%0d c=%0d want 1/0/4", retire_valid, retire_base, retire_count); end
        do_ack();
        checks++; if (head !== 5'd4) begin errors++; $display("FAIL t1_head got %0d want 4", head); end
        checks++; if (num_free !== 6'd32) begin errors++; $display("FAIL t1_free got %0d want 32", num_free); end
        checks++; if (retire_valid !== 1'b0) begin errors++; $display("FAIL t1_rv_after got %0d want 0", retire_valid); end
    endtask

    task automatic test_head_gap();
        do_reset();
        do_alloc(4);
        do_complete(1, 1, 0, 1, 2, 0);
        do_complete(1, 3, 0, 0, 0, 0);
        checks++; if ({retire_valid, retire_count} !== {1'b0, 3'd0}) begin errors++;
            $display("FAIL t2_gap got v=%0d c=%0d want 0/0", retire_valid, retire_count); end
        do_complete(1, 0, 0, 0, 0, 0);
        checks++; if ({retire_valid, retire_count} !== {1'b1, 3'd4}) begin errors++;
            $display("FAIL t2_fill got v=%0d c=%0d want 1/4", retire_valid, retire_count); end
    endtask

    task automatic test_exception();
        do_reset();
        do_alloc(4);
        do_complete(1, 0, 0, 1, 1, 0);
        do_complete(1, 2, 1, 0, 0, 0);
        checks++; if ({retire_count, retire_exc} !== {3'd2, 1'b0}) begin errors++;
            $display("FAIL t3_pre got c=%0d e=%0d want 2/0", retire_count, retire_exc); end
        do_ack();
        checks++; if ({retire_base, retire_count, retire_exc} !== {5'd2, 3'd1, 1'b1}) begin errors++;
            $display("FAIL t3_exc got b=%0d c=%0d e=%0d want 2/1/1", retire_base, retire_count, retire_exc); end
        do_ack();
        checks++; if ({head, num_free} !== {5'd3, 6'd31}) begin errors++;
            $display("FAIL t3_after got h=%0d f=%0d want 3/31", head, num_free); end
    endtask

    task automatic test_same_entry();
        do_reset();
        do_alloc(1);
        do_complete(1, 0, 0, 1, 0, 1);
        checks++; if ({retire_count, retire_exc} !== {3'd1, 1'b1}) begin errors++;
            $display("FAIL dual_port got c=%0d e=%0d want 1/1", retire_count, retire_exc); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int g = 0; g < 15; g++) begin
            do_alloc(2);
            do_complete(1, 2*g, 0, 1, 2*g+1, 0);
            do_ack();
        end
        checks++; if ({head, tail} !== {5'd30, 5'd30}) begin errors++;
            $display("FAIL t4_advance got h=%0d t=%0d want 30/30", head, tail); end
        do_alloc(4);
        checks++; if (tail !== 5'd2) begin errors++; $display("FAIL t4_tail got %0d want 2", tail); end
        do_complete(1, 30, 0, 1, 31, 0);
        checks++; if (retire_count !== 3'd2) begin errors++; $display("FAIL t4_grow got %0d want 2", retire_count); end
        do_complete(1, 0, 0, 1, 1, 0);
        checks++; if ({retire_base, retire_count} !== {5'd30, 3'd4}) begin errors++;
            $display("FAIL t4_group got b=%0d c=%0d want 30/4", retire_base, retire_count); end
        do_ack();
        checks++; if ({head, num_free} !== {5'd2, 6'd32}) begin errors++;
            $display("FAIL t4_head got h=%0d f=%0d want 2/32", head, num_free); end
    endtask

    task automatic test_full();
        do_reset();
        for (int g = 0; g < 7; g++) do_alloc(4);
        checks++; if ({alloc_ready, num_free} !== {1'b1, 6'd4}) begin errors++;
            $display("FAIL t5_edge got r=%0d f=%0d want 1/4", alloc_ready, num_free); end
        do_alloc(4);
        checks++; if ({alloc_ready, num_free, tail} !== {1'b0, 6'd0, 5'd0}) begin errors++;
            $display("FAIL t5_full got r=%0d f=%0d t=%0d want 0/0/0", alloc_ready, num_free, tail); end
        do_complete(1, 0, 0, 1, 1, 0);
        do_complete(1, 2, 0, 1, 3, 0);
        alloc_valid = 1'b1;
        alloc_count = 3'd4;
        do_ack();
        alloc_valid = 1'b0;
        checks++; if ({num_free, tail, head} !== {6'd4, 5'd0, 5'd4}) begin errors++;
            $display("FAIL t5_ack_alloc got f=%0d t=%0d h=%0d want 4/0/4", num_free, tail, head); end
    endtask

    task automatic test_flush();
        do_reset();
        do_alloc(4);
        do_alloc(4);
        do_alloc(2);
        do_complete(1, 0, 0, 1, 1, 0);
        checks++; if ({num_free, retire_valid} !== {6'd22, 1'b1}) begin errors++;
            $display("FAIL t6_pre got f=%0d v=%0d want 22/1", num_free, retire_valid); end
        flush = 1'b1;
        retire_ack = 1'b1;
        alloc_valid = 1'b1;
        alloc_count = 3'd2;
        complete_valid = 2'b11;
        complete_commit = {5'd3, 5'd2};
        cyc();
        {flush, retire_ack, alloc_valid, complete_valid} = '0;
        checks++; if ({head, tail, num_free, retire_valid} !== {5'd0, 5'd0, 6'd32, 1'b0}) begin errors++;
            $display("FAIL t6_flush got h=%0d t=%0d f=%0d v=%0d want 0/0/32/0", head, tail, num_free, retire_valid); end
    endtask

    initial begin
        test_reset();
        test_basic_retire();
        test_head_gap();
        test_exception();
        test_same_entry();
        test_wrap();
        test_full();
        test_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
